instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Fetch stage of the LITE-16 core, directly upstream of register_fetch_unit. Owns the PC and fetches 16-bit instructions over a single-outstanding req/ack memory port. Splits each instruction into nibble fields and decodes the ri/st/jmp/fn control flags that drive register_fetch_unit. Presents each decoded instruction through a valid/ready handshake, stalls after jumps until execute redirects the PC, and stops permanently on HALT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset (word address)

Ports:
clk  in  1  clock, all state updates on its rising edge
rst  in  1  reset; one clock, synchronous, active-high
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  16  fetch word address; equals PC, stable while imem_req=1
imem_ack  in  1  memory response valid; may arrive in the same cycle as imem_req
imem_rdata  in  16  instruction word; sampled only when imem_req && imem_ack
out_valid  out  1  decoded instruction available to register_fetch_unit
out_ready  in  1  downstream accepts the instruction when out_valid && out_ready
i4_7  out  4  instr[7:4]
i8_11  out  4  instr[11:8]
i12_15  out  4  instr[15:12]
ri  out  1  register/immediate operand select
st  out  1  store; suppresses register write
jmp  out  1  jump class
fn  out  1  write destination is i8_11 instead of i12_15
pc_out  out  16  address of the presented instruction
redirect_valid  in  1  execute supplies the jump target
redirect_pc  in  16  jump target address
halted  out  1  HALT reached; core stopped

Behaviour:
- Opcode is instr[3:0]. Decode:
  - 00xx: ALU register form; all flags 0.
  - 01xx: ALU immediate form; ri=1.
  - 10x0: load; flags 0.
  - 10x1: store; st=1.
  - 1100: jump; jmp=1.
  - 1101: jump-and-link; jmp=1, fn=1.
  - 1110: reserved; decodes as all flags 0.
  - 1111: HALT.
- Reset, when rst=1 at an edge: PC=RESET_PC; state=REQ; imem_req=0; out_valid=0; all field, flag and pc_out outputs=0; halted=0. rst has priority over every other input.
- State REQ:
  - imem_req=1 from the cycle after entry; imem_addr=PC.
  - On imem_ack: capture rdata into the instruction register, set pc_out=PC, set PC=PC+1 (16'hFFFF wraps to 16'h0000).
  - If the captured word is HALT, go to HALTED. Otherwise go to ISSUE.
  - imem_req drops in the cycle after ack.
  - Minimum latency: ack in cycle N gives out_valid=1 in cycle N+1.
- State ISSUE:
  - out_valid=1. Fields, flags and pc_out are registered and held stable until the handshake.
  - On out_valid && out_ready: clear out_valid next cycle. If jmp=1, go to WAIT_REDIRECT; otherwise go to REQ.
- State WAIT_REDIRECT:
  - imem_req=0 and out_valid=0. No speculative fetch.
  - On redirect_valid: PC=redirect_pc, go to REQ.
  - A redirect is legal from the first cycle after the jump handshake onward.
- State HALTED:
  - halted=1, imem_req=0, out_valid=0.
  - Leaves only on rst.
  - HALT itself is never presented downstream.
- redirect_valid outside WAIT_REDIRECT is ignored. The bench flags it as a protocol error.
- Reset mid-fetch: the memory is reset by the same rst, so no stale ack is delivered after reset. The request restarts at RESET_PC in the cycle after rst deasserts.
- At most one memory request is outstanding. There is no instruction buffering beyond the single instruction register.

Decomposition:
- Package lite16_pkg holds:
  - the opcode constants (OP_HALT=4'hF, OP_JMP=4'hC, OP_JAL=4'hD, class masks);
  - the fetch state encoding (REQ, ISSUE, WAIT_REDIRECT, HALTED);
  - the instruction field bit positions.
- Sub-module instruction_decoder: combinational; maps the 16-bit instruction word to i4_7, i8_11, i12_15, ri, st, jmp, fn and is_halt. It is reused by bench checkers.

Test Plan:
1. Reset: assert rst for 2 cycles with RESET_PC=16'h0000 -> all outputs 0, halted=0. The cycle after release imem_req=1 with imem_addr=16'h0000.
2. Sequential fetch, ack delayed 3 cycles, out_ready=1: memory {0:16'h3210, 1:16'h5434} -> presentation 1 shows i12_15=3, i8_11=2, i4_7=1, pc_out=0, all flags 0. Presentation 2 shows ri=1, pc_out=1. Next imem_addr=2.
3. Backpressure: out_ready=0 for 5 cycles on store word 16'hABC9 -> st=1 and all fields stay stable. imem_req stays 0 until the handshake, then requests address+1.
4. Jump-and-link: word 16'h000D at 16'h0010 -> jmp=1, fn=1. After the handshake there is no request. redirect_valid with redirect_pc=16'h0100 is followed by imem_addr=16'h0100.
5. HALT and PC wrap: RESET_PC=16'hFFFF, word 16'h000F at 16'h0000 after one ALU word -> ALU word presented with pc_out=16'hFFFF. The next fetch is at 16'h0000, then halted=1 with no out_valid and no further imem_req.
6. Mid-fetch reset: assert rst while imem_req=1 and ack is pending -> next request is at RESET_PC, out_valid stays 0, and the spurious redirect_valid is ignored.

Source files
------------

// File: rtl/lite16_pkg.sv
// Shared LITE-16 definitions: opcode constants, instruction field positions
// and the fetch-stage state encoding.
package lite16_pkg;

    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JAL  = 4'hD;

    // Top two opcode bits select the instruction class.
    localparam logic [3:0] OP_CLASS_MASK  = 4'hC;
    localparam logic [3:0] OP_CLASS_ALU_R = 4'h0;
    localparam logic [3:0] OP_CLASS_ALU_I = 4'h4;
    localparam logic [3:0] OP_CLASS_MEM   = 4'h8;
    localparam logic [3:0] OP_CLASS_CTRL  = 4'hC;

    localparam int FIELD_W  = 4;
    localparam int OP_LSB   = 0;
    localparam int F4_LSB   = 4;
    localparam int F8_LSB   = 8;
    localparam int F12_LSB  = 12;

    typedef enum logic [1:0] {
        FS_REQ           = 2'd0,
        FS_ISSUE         = 2'd1,
        FS_WAIT_REDIRECT = 2'd2,
        FS_HALTED        = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_decoder.sv
// Combinational LITE-16 decode: nibble fields plus the ri/st/jmp/fn control
// flags consumed by register fetch, and HALT detection.
module instruction_decoder
    import lite16_pkg::*;
(
    input  logic [15:0] i_instr,
    output logic [3:0]  o_i4_7,
    output logic [3:0]  o_i8_11,
    output logic [3:0]  o_i12_15,
    output logic        o_ri,
    output logic        o_st,
    output logic        o_jmp,
    output logic        o_fn,
    output logic        o_is_halt
);

    logic [3:0] w_op;
    logic [3:0] w_class;

    assign w_op    = i_instr[OP_LSB +: FIELD_W];
    assign w_class = w_op & OP_CLASS_MASK;

    assign o_i4_7   = i_instr[F4_LSB  +: FIELD_W];
    assign o_i8_11  = i_instr[F8_LSB  +: FIELD_W];
    assign o_i12_15 = i_instr[F12_LSB +: FIELD_W];

    // Reserved 1110 and HALT fall through with every flag clear.
    assign o_ri      = (w_class == OP_CLASS_ALU_I);
    assign o_st      = (w_class == OP_CLASS_MEM) && w_op[0];
    assign o_jmp     = (w_op == OP_JMP) || (w_op == OP_JAL);
    assign o_fn      = (w_op == OP_JAL);
    assign o_is_halt = (w_op == OP_HALT);

endmodule

// File: rtl/instruction_fetch_unit.sv
// LITE-16 fetch stage: owns the PC, fetches over a single-outstanding req/ack
// port, presents decoded instructions via valid/ready, stalls on jumps.
module instruction_fetch_unit
    import lite16_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  i4_7,
    output logic [3:0]  i8_11,
    output logic [3:0]  i12_15,
    output logic        ri,
    output logic        st,
    output logic        jmp,
    output logic        fn,
    output logic [15:0] pc_out,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        halted
);

    fetch_state_t r_state;
    logic [15:0]  r_pc;
    logic [15:0]  r_pc_out;
    logic         r_req;
    logic         r_valid;
    logic         r_halted;
    logic [3:0]   r_i4_7, r_i8_11, r_i12_15;
    logic         r_ri, r_st, r_jmp, r_fn;

    logic [3:0]   w_i4_7, w_i8_11, w_i12_15;
    logic         w_ri, w_st, w_jmp, w_fn, w_is_halt;

    instruction_decoder u_decoder (
        .i_instr   (imem_rdata),
        .o_i4_7    (w_i4_7),
        .o_i8_11   (w_i8_11),
        .o_i12_15  (w_i12_15),
        .o_ri      (w_ri),
        .o_st      (w_st),
        .o_jmp     (w_jmp),
        .o_fn      (w_fn),
        .o_is_halt (w_is_halt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= FS_REQ;
            r_pc     <= RESET_PC;
            r_pc_out <= 16'h0000;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_i4_7   <= 4'h0;
            r_i8_11  <= 4'h0;
            r_i12_15 <= 4'h0;
            r_ri     <= 1'b0;
            r_st     <= 1'b0;
            r_jmp    <= 1'b0;
            r_fn     <= 1'b0;
        end else begin
            case (r_state)
                FS_REQ: begin
                    // Request rises the cycle after entry; the word is decoded as it lands.
                    if (r_req && imem_ack) begin
                        r_req    <= 1'b0;
                        r_pc     <= r_pc + 16'd1;
                        r_pc_out <= r_pc;
                        if (w_is_halt) begin
                            r_state  <= FS_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_state  <= FS_ISSUE;
                            r_valid  <= 1'b1;
                            r_i4_7   <= w_i4_7;
                            r_i8_11  <= w_i8_11;
                            r_i12_15 <= w_i12_15;
                            r_ri     <= w_ri;
                            r_st     <= w_st;
                            r_jmp    <= w_jmp;
                            r_fn     <= w_fn;
                        end
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                FS_ISSUE: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= r_jmp ? FS_WAIT_REDIRECT : FS_REQ;
                    end
                end
                FS_WAIT_REDIRECT: begin
                    if (redirect_valid) begin
                        r_pc    <= redirect_pc;
                        r_state <= FS_REQ;
                    end
                end
                FS_HALTED: begin
                    r_state <= FS_HALTED;
                end
                default: begin
                    r_state <= FS_REQ;
                end
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_pc;
    assign out_valid = r_valid;
    assign i4_7      = r_i4_7;
    assign i8_11     = r_i8_11;
    assign i12_15    = r_i12_15;
    assign ri        = r_ri;
    assign st        = r_st;
    assign jmp       = r_jmp;
    assign fn        = r_fn;
    assign pc_out    = r_pc_out;
    assign halted    = r_halted;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: random program walk against a queue-based
// reference, plus directed reset, PC-wrap/HALT and mid-fetch reset scenarios.
module tb_instruction_fetch_unit;

    localparam int N_INSTR = 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, RESET_PC = 0
    logic        rst, imem_req, imem_ack, out_valid, out_ready;
    logic [15:0] imem_addr, imem_rdata, pc_out, redirect_pc;
    logic [3:0]  i4_7, i8_11, i12_15;
    logic        ri, st, jmp, fn, redirect_valid, halted;

    // Wrap instance, RESET_PC = 16'hFFFF
    logic        rst_b, req_b, ack_b, valid_b, ready_b;
    logic [15:0] addr_b, rdata_b, pc_out_b, redir_pc_b;
    logic [3:0]  i4_7_b, i8_11_b, i12_15_b;
    logic        ri_b, st_b, jmp_b, fn_b, redir_b, halted_b;

    instruction_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .i4_7(i4_7), .i8_11(i8_11), .i12_15(i12_15),
        .ri(ri), .st(st), .jmp(jmp), .fn(fn), .pc_out(pc_out),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
    );

    instruction_fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst(rst_b), .imem_req(req_b), .imem_addr(addr_b),
        .imem_ack(ack_b), .imem_rdata(rdata_b), .out_valid(valid_b),
        .out_ready(ready_b), .i4_7(i4_7_b), .i8_11(i8_11_b), .i12_15(i12_15_b),
        .ri(ri_b), .st(st_b), .jmp(jmp_b), .fn(fn_b), .pc_out(pc_out_b),
        .redirect_valid(redir_b), .redirect_pc(redir_pc_b), .halted(halted_b)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [15:0] fetch_q[$];
    logic [15:0] tgt_q[$];
    logic [15:0] mem[int];

    bit rand_en = 1'b0;
    bit mon_en  = 1'b0;
    bit done_b  = 1'b0;
    int jmp_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event observed, none expected", name);
    endtask

    // Expected presentation {pc, i12_15, i8_11, i4_7, ri, st, jmp, fn}
    function automatic logic [31:0] ref_entry(input logic [15:0] pc, input logic [15:0] w);
        int op;
        logic e_ri, e_st, e_jmp, e_fn;
        op    = int'(w[3:0]);
        e_ri  = (op >= 4 && op <= 7);
        e_st  = (op >= 8 && op <= 11) && (op % 2 == 1);
        e_jmp = (op == 12 || op == 13);
        e_fn  = (op == 13);
        return {pc, w[15:12], w[11:8], w[7:4], e_ri, e_st, e_jmp, e_fn};
    endfunction

    function automatic logic [31:0] observed();
        return {pc_out, i12_15, i8_11, i4_7, ri, st, jmp, fn};
    endfunction

    // Walk the program as the core would execute it, filling memory lazily.
    task automatic build_program();
        logic [15:0] pc, w, t;
        logic [15:0] pre_w[5];
        logic [15:0] pre_t[2];
        int k, jt;
        pre_w = '{16'h3210, 16'h5434, 16'hABC9, 16'h000C, 16'h000D};
        pre_t = '{16'h0010, 16'h0100};
        pc = 16'h0000;
        k = 0;
        jt = 0;
        for (int s = 0; s < 4000; s++) begin
            if (mem.exists(int'(pc))) begin
                w = mem[int'(pc)];
            end else if (k >= N_INSTR) begin
                mem[int'(pc)] = 16'hF00F;
                fetch_q.push_back(pc);
                return;
            end else begin
                if (k < 5) begin
                    w = pre_w[k];
                end else begin
                    w = 16'($urandom_range(0, 16'hFFFF));
                    w[3:0] = 4'($urandom_range(0, 14));
                end
                mem[int'(pc)] = w;
            end
            fetch_q.push_back(pc);
            exp_q.push_back(ref_entry(pc, w));
            k++;
            if (w[3:0] == 4'hC || w[3:0] == 4'hD) begin
                t = (jt < 2) ? pre_t[jt] : 16'($urandom_range(0, 16'hFFFF));
                jt++;
                tgt_q.push_back(t);
                pc = t;
            end else begin
                pc = pc + 16'd1;
            end
        end
        fail("program_build");
    endtask

    // Memory responder: random 0..3 cycle ack latency
    initial begin : responder
        int delay;
        bit busy;
        logic [15:0] held_addr;
        busy = 1'b0;
        delay = 0;
        held_addr = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rand_en) begin
                busy = 1'b0;
                continue;
            end
            if (imem_ack) begin
                imem_ack = 1'b0;
            end else if (imem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    delay = $urandom_range(0, 3);
                    held_addr = imem_addr;
                    if (fetch_q.size() == 0) fail("fetch_unexpected");
                    else check("fetch_addr", {16'h0, imem_addr}, {16'h0, fetch_q.pop_front()});
                end else begin
                    check("addr_stable", {16'h0, imem_addr}, {16'h0, held_addr});
                end
                if (delay == 0) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem.exists(int'(imem_addr)) ? mem[int'(imem_addr)] : 16'h0000;
                    busy = 1'b0;
                end else begin
                    delay--;
                end
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge clk);
            #1;
            if (rand_en) out_ready = ($urandom_range(0, 9) < 7);
        end
    end

    initial begin : redirector
        int d;
        forever begin
            @(posedge clk);
            #1;
            if (rand_en && jmp_seen > 0) begin
                jmp_seen--;
                d = $urandom_range(0, 3);
                repeat (d) @(posedge clk);
                #1;
                if (tgt_q.size() == 0) begin
                    fail("redirect_target_missing");
                    redirect_pc = 16'h0000;
                end else begin
                    redirect_pc = tgt_q.pop_front();
                end
                redirect_valid = 1'b1;
                @(posedge clk);
                #1;
                redirect_valid = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic [31:0] held, obs, e;
        bit hold;
        hold = 1'b0;
        held = 32'h0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                obs = observed();
                if (hold) begin
                    if (out_valid) check("hold_stable", obs, held);
                    else fail("valid_dropped");
                    hold = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail("output_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("decoded", obs, e);
                        if (e[1]) jmp_seen++;
                    end
                end else if (out_valid) begin
                    hold = 1'b1;
                    held = obs;
                end
                if (halted && out_valid) fail("valid_while_halted");
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : wrap_test
        int nf, npres;
        rst_b = 1'b1; ack_b = 1'b0; rdata_b = 16'h0; ready_b = 1'b1;
        redir_b = 1'b0; redir_pc_b = 16'h0;
        nf = 0;
        npres = 0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (ack_b) begin
                ack_b = 1'b0;
            end else if (req_b) begin
                if (nf < 2) check("wrap_fetch_addr", {16'h0, addr_b}, (nf == 0) ? 32'h0000FFFF : 32'h0);
                else fail("wrap_extra_fetch");
                ack_b = 1'b1;
                rdata_b = (addr_b == 16'hFFFF) ? 16'h1230 : 16'h000F;
                nf++;
            end
            @(negedge clk);
            if (valid_b) begin
                if (npres == 0)
                    check("wrap_present", {pc_out_b, i12_15_b, i8_11_b, i4_7_b, ri_b, st_b, jmp_b, fn_b},
                          {16'hFFFF, 4'h1, 4'h2, 4'h3, 4'b0000});
                else fail("wrap_extra_present");
                npres++;
            end
        end
        check("wrap_fetch_count", nf, 2);
        check("wrap_present_count", npres, 1);
        check("wrap_halted", {29'h0, halted_b, req_b, valid_b}, 32'h4);
        done_b = 1'b1;
    end

    initial begin : main
        bit seen_halt;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 16'h0;
        build_program();

        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ctrl", {25'h0, imem_req, out_valid, halted, ri, st, jmp, fn}, 32'h0);
        check("rst_fields", {20'h0, i12_15, i8_11, i4_7}, 32'h0);
        check("rst_pc_out", {16'h0, pc_out}, 32'h0);
        @(negedge clk);
        check("first_req", {15'h0, imem_req, imem_addr}, 32'h0001_0000);

        // Random program run until HALT
        rand_en = 1'b1;
        mon_en = 1'b1;
        seen_halt = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (halted) begin
                seen_halt = 1'b1;
                break;
            end
        end
        if (!seen_halt) fail("halt_timeout");
        repeat (5) begin
            @(negedge clk);
            check("halted_quiet", {29'h0, halted, imem_req, out_valid}, 32'h4);
        end
        check("exp_q_drained", exp_q.size(), 0);
        check("fetch_q_drained", fetch_q.size(), 0);
        check("tgt_q_drained", tgt_q.size(), 0);

        // Mid-fetch reset with spurious redirect
        rand_en = 1'b0;
        mon_en = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst2_req", {14'h0, halted, imem_req, imem_addr}, 32'h0001_0000);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h1234;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst3_idle", {30'h0, imem_req, out_valid}, 32'h0);
        @(negedge clk);
        check("rst3_req", {15'h0, imem_req, imem_addr}, 32'h0001_0000);
        @(posedge clk); #1;
        imem_ack = 1'b1;
        imem_rdata = 16'h3210;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rst3_valid", {31'h0, out_valid}, 32'h1);
        check("rst3_present", observed(), {16'h0000, 4'h3, 4'h2, 4'h1, 4'b0000});

        for (int c = 0; c < 100 && !done_b; c++) @(negedge clk);
        if (!done_b) fail("wrap_test_timeout");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
